telemetry_frame_parser: RTL
===========================

Name: telemetry_frame_parser

Overview:
- Consumes the byte stream produced by the UART receiver: one `rx_data` byte per `rx_valid` strobe.
- Delineates telemetry frames of the form SYNC, ID, LEN, LEN payload bytes, CSUM.
- Buffers the payload and releases it downstream only after the checksum passes, over a valid/ready stream.
- Reports frame completion and categorized errors to the board status logic.

Parameters:
- SYNC_BYTE, 8'hA5: frame start marker, recognized only while hunting.
- MAX_PAYLOAD, 16: maximum legal LEN and payload buffer depth (>=1).
- TIMEOUT_CYCLES, 104160: max idle clocks between bytes inside a frame (two byte-times at 9600 baud, 50 MHz).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- rx_data  in  8  byte from UART receiver, qualified by rx_valid.
- rx_valid  in  1  single-cycle strobe, one per received byte.
- out_data  out  8  payload byte.
- out_valid  out  1  payload byte available.
- out_ready  in  1  downstream accepts byte when high with out_valid.
- out_last  out  1  marks final payload byte of frame.
- frame_id  out  8  ID of current/last good frame, held until next good frame.
- frame_len  out  LEN_W  LEN of current/last good frame; LEN_W = $clog2(MAX_PAYLOAD+1).
- frame_ok  out  1  one-cycle pulse, checksum matched.
- frame_err  out  1  one-cycle pulse, error detected.
- err_code  out  3  valid with frame_err: 1 CSUM, 2 LEN, 3 TIMEOUT, 4 OVERRUN; otherwise 0.
- busy  out  1  high in any state except HUNT.

Behaviour:
- Reset, asynchronous: state HUNT.
  - out_valid, out_last, frame_ok, frame_err, busy = 0.
  - out_data, frame_id, frame_len, err_code = 0.
  - Checksum, write and read pointers, and timeout counter = 0.
- All outputs are registered; frame_ok and frame_err appear the cycle after the triggering rx_valid.
- Checksum is the 8-bit sum mod 256 of ID, LEN and all payload bytes; SYNC and CSUM are excluded.
- States and transitions, evaluated on rx_valid:
  - HUNT: byte==SYNC_BYTE -> ID; other bytes are discarded silently.
  - ID: store ID, checksum=byte -> LEN. A SYNC_BYTE value here is data, not a resync.
  - LEN: LEN > MAX_PAYLOAD -> err LEN, -> HUNT. LEN==0 -> CSUM. Otherwise -> PAYLOAD, with wr_ptr=0.
  - PAYLOAD: write buf[wr_ptr], add to checksum, wr_ptr++. When wr_ptr reaches LEN-1 on this write -> CSUM.
  - CSUM, mismatch: err CSUM -> HUNT. frame_id and frame_len are unchanged.
  - CSUM, match: frame_ok pulse; update frame_id and frame_len. LEN==0 -> HUNT; else -> DRAIN with rd_ptr=0.
  - DRAIN: out_valid=1, out_data=buf[rd_ptr], out_last=(rd_ptr==frame_len-1).
    - On out_valid && out_ready: rd_ptr++.
    - On the last handshake: out_valid=0 next cycle -> HUNT.
    - out_data and out_last are stable while out_valid && !out_ready.
- Timeout:
  - The counter clears on every rx_valid and counts only in ID, LEN, PAYLOAD and CSUM.
  - Reaching TIMEOUT_CYCLES -> err TIMEOUT -> HUNT; partial buffer contents are abandoned.
  - The counter does not run in HUNT or DRAIN.
- Overrun:
  - rx_valid in DRAIN: byte dropped, err OVERRUN pulse, state unchanged.
  - This includes the cycle of the final handshake; that byte is dropped even if it equals SYNC_BYTE.
- An error and a frame_ok never occur in the same cycle. At most one error is reported per cycle.
  - Timeout expiry and rx_valid in the same cycle: the byte wins and the counter clears.
- Reset mid-frame or mid-DRAIN: immediate return to HUNT. out_valid drops asynchronously and no pulses are emitted.

Decomposition:
- telemetry_pkg:
  - Parser state enum: HUNT, ID, LEN, PAYLOAD, CSUM, DRAIN.
  - err_code enum: NONE=0, CSUM=1, LEN=2, TIMEOUT=3, OVERRUN=4.
  - Default SYNC_BYTE constant.
- One sub-module, frame_buffer:
  - MAX_PAYLOAD x 8 register array.
  - One synchronous write port and one asynchronous read port indexed by rd_ptr.
  - No reset on storage.

Test Plan:
- Good frame: A5 01 03 10 20 30 64 with out_ready=1 -> frame_ok pulse; frame_id=01, frame_len=3; out_data 10,20,30 with out_last on 30; busy falls after.
- Backpressure: same frame, out_ready low for 5 cycles mid-drain -> out_data holds 20 stable; order and out_last unchanged.
- Bad checksum: A5 01 03 10 20 30 65 -> frame_err, err_code=1, no out_valid; then A5 02 00 02 -> frame_ok, frame_len=0, no out_valid.
- Length error and resync: garbage 00 FF, then A5 07 11 -> err_code=2; next valid frame is accepted normally.
- Timeout: A5 01, then no bytes for TIMEOUT_CYCLES -> err_code=3, busy=0; an immediate good frame passes.
- Overrun and reset: byte during DRAIN -> err_code=4 and payload intact. Separately, rst asserted mid-PAYLOAD -> all outputs at reset values; next frame parses correctly.

Source files
------------

// File: rtl/telemetry_pkg.sv
// telemetry_pkg: shared state/error encodings and constants for the telemetry frame parser.
package telemetry_pkg;
    localparam int BYTE_W = 8;
    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
    typedef enum logic [2:0] {S_HUNT, S_ID, S_LEN, S_PAYLOAD, S_CSUM, S_DRAIN} state_t;
    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_CSUM    = 3'd1,
        ERR_LEN     = 3'd2,
        ERR_TIMEOUT = 3'd3,
        ERR_OVERRUN = 3'd4
    } err_t;
endpackage

// File: rtl/telemetry_frame_parser_buffer.sv
// frame_buffer: payload store with one synchronous write port and one asynchronous read port.
module frame_buffer
    import telemetry_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [BYTE_W-1:0] rd_data
);
    logic [BYTE_W-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (wr_en) mem[wr_addr] <= wr_data;
    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/telemetry_frame_parser.sv
// telemetry_frame_parser: delineates SYNC/ID/LEN/payload/CSUM frames from a UART byte stream
// and releases checksum-verified payloads over a valid/ready stream.
module telemetry_frame_parser
    import telemetry_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT,
    parameter int MAX_PAYLOAD = 16,
    parameter int TIMEOUT_CYCLES = 104160,
    localparam int LEN_W = $clog2(MAX_PAYLOAD + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [7:0]       frame_id,
    output logic [LEN_W-1:0] frame_len,
    output logic             frame_ok,
    output logic             frame_err,
    output logic [2:0]       err_code,
    output logic             busy
);
    localparam int AW = MAX_PAYLOAD > 1 ? $clog2(MAX_PAYLOAD) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    state_t state;
    logic [7:0] csum, id_q, rd_data;
    logic [LEN_W-1:0] len_q, wr_ptr, rd_ptr;
    logic [TW-1:0] tmo;
    logic wr_en;
    assign wr_en = rx_valid && state == S_PAYLOAD;
    frame_buffer #(.DEPTH(MAX_PAYLOAD), .AW(AW)) u_buf (
        .clk(clk),
        .wr_en(wr_en),
        .wr_addr(wr_ptr[AW-1:0]),
        .wr_data(rx_data),
        .rd_addr(rd_ptr[AW-1:0]),
        .rd_data(rd_data)
    );
    // rd_ptr runs one byte ahead of out_data so the output stays a plain register.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state     <= S_HUNT;
            csum      <= '0;
            id_q      <= '0;
            len_q     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            tmo       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            frame_id  <= '0;
            frame_len <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= ERR_NONE;
            busy      <= 1'b0;
        end else begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= ERR_NONE;
            if (rx_valid || state == S_HUNT || state == S_DRAIN) tmo <= '0;
            else if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                tmo       <= '0;
                state     <= S_HUNT;
                busy      <= 1'b0;
                frame_err <= 1'b1;
                err_code  <= ERR_TIMEOUT;
            end else tmo <= tmo + TW'(1);
            case (state)
                S_HUNT: if (rx_valid && rx_data == SYNC_BYTE) begin
                    state <= S_ID;
                    busy  <= 1'b1;
                end
                S_ID: if (rx_valid) begin
                    id_q  <= rx_data;
                    csum  <= rx_data;
                    state <= S_LEN;
                end
                S_LEN: if (rx_valid) begin
                    csum   <= csum + rx_data;
                    len_q  <= LEN_W'(rx_data);
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    if (int'(rx_data) > MAX_PAYLOAD) begin
                        state     <= S_HUNT;
                        busy      <= 1'b0;
                        frame_err <= 1'b1;
                        err_code  <= ERR_LEN;
                    end else state <= rx_data == 8'd0 ? S_CSUM : S_PAYLOAD;
                end
                S_PAYLOAD: if (rx_valid) begin
                    csum   <= csum + rx_data;
                    wr_ptr <= wr_ptr + LEN_W'(1);
                    if (wr_ptr == len_q - LEN_W'(1)) state <= S_CSUM;
                end
                S_CSUM: if (rx_valid) begin
                    if (rx_data != csum) begin
                        state     <= S_HUNT;
                        busy      <= 1'b0;
                        frame_err <= 1'b1;
                        err_code  <= ERR_CSUM;
                    end else begin
                        frame_ok  <= 1'b1;
                        frame_id  <= id_q;
                        frame_len <= len_q;
                        if (len_q == '0) begin
                            state <= S_HUNT;
                            busy  <= 1'b0;
                        end else begin
                            state     <= S_DRAIN;
                            out_valid <= 1'b1;
                            out_data  <= rd_data;
                            out_last  <= len_q == LEN_W'(1);
                            rd_ptr    <= LEN_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (rx_valid) begin
                        frame_err <= 1'b1;
                        err_code  <= ERR_OVERRUN;
                    end
                    if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            state     <= S_HUNT;
                            busy      <= 1'b0;
                        end else begin
                            out_data <= rd_data;
                            out_last <= rd_ptr == len_q - LEN_W'(1);
                            rd_ptr   <= rd_ptr + LEN_W'(1);
                        end
                    end
                end
                default: state <= S_HUNT;
            endcase
        end
endmodule
